// File: rtl/onset_minterm_enumerator.sv
// rtl/onset_minterm_enumerator.sv - sweeps all input vectors of a function block and streams the matching minterms
module onset_minterm_enumerator #(
    parameter int N_IN         = 8,
    parameter int SAMPLE_DELAY = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            polarity,
    output logic [N_IN-1:0] x,
    input  logic            y,
    output logic            m_valid,
    output logic [N_IN-1:0] m_data,
    input  logic            m_ready,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   count
);

    // Delay counter only needs to reach SAMPLE_DELAY; keep at least one bit.
    localparam int DW = (SAMPLE_DELAY > 0) ? $clog2(SAMPLE_DELAY + 1) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(SAMPLE_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        EMIT  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [N_IN-1:0] x_n, m_data_n;
    logic            m_valid_n, busy_n, done_n;
    logic [N_IN:0]   count_n;
    logic            pol, pol_n;
    logic [DW-1:0]   dly, dly_n;
    logic            adv;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers; reset aborts a sweep without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            count   <= '0;
            pol     <= 1'b0;
            dly     <= '0;
        end else begin
            x       <= x_n;
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            busy    <= busy_n;
            done    <= done_n;
            count   <= count_n;
            pol     <= pol_n;
            dly     <= dly_n;
        end
    end

    // Next-state logic; adv marks the edge that moves to the next vector or ends the sweep.
    always_comb begin
        state_n   = state;
        x_n       = x;
        m_valid_n = m_valid;
        m_data_n  = m_data;
        busy_n    = busy;
        done_n    = 1'b0;
        count_n   = count;
        pol_n     = pol;
        dly_n     = dly;
        adv       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    x_n     = '0;
                    count_n = '0;
                    pol_n   = polarity;
                    dly_n   = '0;
                    busy_n  = 1'b1;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (dly == DLY_LAST) begin
                    if (y == pol) begin
                        m_data_n  = x;
                        m_valid_n = 1'b1;
                        state_n   = EMIT;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    dly_n = dly + 1'b1;
                end
            end
            EMIT: begin
                if (m_valid && m_ready) begin
                    m_valid_n = 1'b0;
                    count_n   = count + 1'b1;
                    adv       = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The all-ones vector is the last one; x never wraps.
        if (adv) begin
            if (x != '1) begin
                x_n     = x + 1'b1;
                dly_n   = '0;
                state_n = DRIVE;
            end else begin
                state_n = IDLE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_onset_minterm_enumerator.sv
// tb/tb_onset_minterm_enumerator.sv - self-checking bench with a minterm-list reference model
module tb_onset_minterm_enumerator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic       polarity;
    logic       m_ready;
    logic [7:0] x0, x1, md0, md1;
    logic       y0, y1;
    logic       mv0, mv1, busy0, busy1, done0, done1;
    logic [8:0] cnt0, cnt1;

    logic       tbl [256];
    logic       p1, p2;

    logic       sel_g;
    logic [7:0] cx, cmd;
    logic       cv, cb, cd;
    logic [8:0] ccnt;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         got[$];
    int         exp_q[$];
    int         done_cycle;
    bit         vseen;

    always #5 clk = ~clk;

    onset_minterm_enumerator #(.N_IN(8), .SAMPLE_DELAY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .polarity(polarity),
        .x(x0), .y(y0), .m_valid(mv0), .m_data(md0), .m_ready(m_ready),
        .busy(busy0), .done(done0), .count(cnt0)
    );

    onset_minterm_enumerator #(.N_IN(8), .SAMPLE_DELAY(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .polarity(polarity),
        .x(x1), .y(y1), .m_valid(mv1), .m_data(md1), .m_ready(m_ready),
        .busy(busy1), .done(done1), .count(cnt1)
    );

    // Function block: combinational for dut0, two-stage registered for dut1.
    assign y0 = tbl[x0];
    always @(posedge clk) begin
        p1 <= tbl[x1];
        p2 <= p1;
    end
    assign y1 = p2;

    assign cx   = sel_g ? x1    : x0;
    assign cmd  = sel_g ? md1   : md0;
    assign cv   = sel_g ? mv1   : mv0;
    assign cb   = sel_g ? busy1 : busy0;
    assign cd   = sel_g ? done1 : done0;
    assign ccnt = sel_g ? cnt1  : cnt0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_x"},     32'(cx),   32'd0);
        chk({tag, "_valid"}, 32'(cv),   32'd0);
        chk({tag, "_data"},  32'(cmd),  32'd0);
        chk({tag, "_busy"},  32'(cb),   32'd0);
        chk({tag, "_done"},  32'(cd),   32'd0);
        chk({tag, "_count"}, 32'(ccnt), 32'd0);
    endtask

    // Reference: every vector whose function value equals the polarity, ascending.
    function automatic void build_exp(input logic pol);
        exp_q.delete();
        for (int v = 0; v < 256; v++)
            if (tbl[v] == pol) exp_q.push_back(v);
    endfunction

    task automatic check_list(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_item"}, 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_count"}, 32'(ccnt), 32'(exp_q.size()));
    endtask

    task automatic run_sweep(input logic sel, input logic pol, input int rmode,
                             input int stall_val, input int stall_len,
                             input int abort_at, input bit poke);
        int c;
        int stall;
        bit fin;
        bit stalling;
        got.delete();
        done_cycle = -1;
        vseen      = 0;
        stall      = stall_len;
        stalling   = 0;
        fin        = 0;
        c          = 0;
        sel_g      = sel;
        polarity   = pol;
        m_ready    = 1'b1;
        @(negedge clk);
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        while (!fin && c < 3000) begin
            start0 = 1'b0;
            start1 = 1'b0;
            if (cd) begin
                done_cycle = c;
                fin = 1;
            end else begin
                if (cv) vseen = 1;
                m_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (stalling && stall > 0) begin
                    chk("stall_valid", 32'(cv), 32'd1);
                    chk("stall_data", 32'(cmd), 32'(stall_val));
                    chk("stall_x", 32'(cx), 32'(stall_val));
                    m_ready = 1'b0;
                    stall--;
                end else if (!stalling && cv && int'(cmd) == stall_val && stall > 0) begin
                    stalling = 1;
                    m_ready  = 1'b0;
                    stall--;
                end
                if (cv && int'(cmd) == abort_at) begin
                    m_ready = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 chk_idle_zero("abort");
                    repeat (3) begin
                        @(negedge clk);
                        chk("abort_no_done", 32'(cd), 32'd0);
                    end
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("abort_after_done", 32'(cd), 32'd0);
                    chk("abort_after_busy", 32'(cb), 32'd0);
                    fin = 1;
                end
                if (!fin) begin
                    if (cv && m_ready) got.push_back(int'(cmd));
                    if (poke && (c % 37) == 5) start1 = 1'b1;
                    @(negedge clk);
                    c++;
                end
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        chk("sweep_ends", 32'(fin), 32'd1);
        if (done_cycle >= 0) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(cd), 32'd0);
            chk("idle_busy", 32'(cb), 32'd0);
            chk("final_x", 32'(cx), 32'd255);
        end
    endtask

    initial begin
        logic rp;
        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        polarity = 1'b0;
        m_ready  = 1'b1;
        sel_g    = 1'b0;
        for (int v = 0; v < 256; v++) tbl[v] = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset0");
        sel_g = 1'b1;
        chk_idle_zero("reset1");
        rst_n = 1'b1;

        // y = x[0], on-set: odd vectors
        for (int v = 0; v < 256; v++) tbl[v] = v[0];
        run_sweep(1'b0, 1'b1, 0, -1, 0, -1, 1'b0);
        build_exp(1'b1);
        check_list("odd");
        chk("odd_done_cycle", 32'(done_cycle), 32'd384);

        // same function, off-set: even vectors
        run_sweep(1'b0, 1'b0, 0, -1, 0, -1, 1'b0);
        build_exp(1'b0);
        check_list("even");
        chk("even_done_cycle", 32'(done_cycle), 32'd384);

        // y tied 0, on-set is empty
        for (int v = 0; v < 256; v++) tbl[v] = 1'b0;
        run_sweep(1'b0, 1'b1, 0, -1, 0, -1, 1'b0);
        build_exp(1'b1);
        check_list("empty");
        chk("empty_no_valid", 32'(vseen), 32'd0);
        chk("empty_done_cycle", 32'(done_cycle), 32'd256);

        // y tied 1, backpressure of 10 cycles on minterm 5
        for (int v = 0; v < 256; v++) tbl[v] = 1'b1;
        run_sweep(1'b0, 1'b1, 0, 5, 10, -1, 1'b0);
        build_exp(1'b1);
        check_list("full");
        chk("full_done_cycle", 32'(done_cycle), 32'd522);

        // random function, random polarity and random ready
        for (int v = 0; v < 256; v++) tbl[v] = 1'($urandom_range(0, 1));
        rp = 1'($urandom_range(0, 1));
        run_sweep(1'b0, rp, 1, -1, 0, -1, 1'b0);
        build_exp(rp);
        check_list("rand0");

        // registered function, SAMPLE_DELAY=2, with stray start pulses
        for (int v = 0; v < 256; v++) tbl[v] = 1'($urandom_range(0, 1));
        rp = 1'($urandom_range(0, 1));
        run_sweep(1'b1, rp, 1, -1, 0, -1, 1'b1);
        build_exp(rp);
        check_list("pipe");

        // reset while emitting minterm 40, then a clean full sweep
        for (int v = 0; v < 256; v++) tbl[v] = 1'b1;
        run_sweep(1'b0, 1'b1, 0, -1, 0, 40, 1'b0);
        chk("abort_partial_len", 32'(got.size()), 32'd40);
        run_sweep(1'b0, 1'b1, 0, -1, 0, -1, 1'b0);
        build_exp(1'b1);
        check_list("rerun");
        chk("rerun_done_cycle", 32'(done_cycle), 32'd512);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
